// File: rtl/mii_rx_frame_pkg.sv
// rtl/mii_rx_frame_pkg.sv - shared state encoding, descriptor layout and CRC-32 constants
// for the MII receive frame engine.
package mii_rx_frame_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    DATA,
    DESC,
    DROP
  } state_t;

  localparam int CRC_ERR_BIT   = 15;
  localparam int LEN_ERR_BIT   = 14;
  localparam int ALIGN_ERR_BIT = 13;
  localparam int LEN_MSB       = 10;

  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;

  // Reflected CRC-32 over one byte, LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] din);
    logic [31:0] c;
    c = crc ^ {24'h0, din};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/mii_rx_frame_crc32.sv
// rtl/mii_rx_frame_crc32.sv - byte-wide reflected CRC-32 register with init/enable.
module mii_rx_crc32
  import mii_rx_frame_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  din,
  output logic [31:0] crc
);

  logic [31:0] crc_q;
  logic [31:0] crc_d;

  always_comb begin
    crc_d = crc_q;
    if (init) begin
      crc_d = CRC_INIT;
    end else if (en) begin
      crc_d = crc32_byte(crc_q, din);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      crc_q <= CRC_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/mii_rx_frame.sv
// rtl/mii_rx_frame.sv - MII receive frame engine: preamble/SFD detect, byte assembly, FCS/length/
// alignment checks, data and descriptor FIFO writes. MII_RX_STATS_EN adds frame counters.
module mii_rx_frame
  import mii_rx_frame_pkg::*;
#(
  parameter int MIN_LEN    = 64,
  parameter int MAX_LEN    = 1518,
  parameter int FIFO_AFULL = 2566,
  parameter int PRE_MIN    = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        rx_dv,
  input  logic [3:0]  rx_d,
  output logic        data_fifo_wr,
  output logic [7:0]  data_fifo_dout,
  input  logic [11:0] data_fifo_depth,
  output logic        ptr_fifo_wr,
  output logic [15:0] ptr_fifo_dout,
  input  logic        ptr_fifo_full
`ifdef MII_RX_STATS_EN
  ,
  output logic [15:0] frames_ok,
  output logic [15:0] frames_err,
  output logic [15:0] frames_drop
`endif
);

  localparam logic [10:0] MIN_LEN_W    = 11'(MIN_LEN);
  localparam logic [10:0] MAX_LEN_W    = 11'(MAX_LEN);
  localparam logic [11:0] FIFO_AFULL_W = 12'(FIFO_AFULL);
  localparam logic [3:0]  PRE_MIN_W    = 4'(PRE_MIN);

  logic        rx_dv_q, rx_dv_d_q;
  logic [3:0]  rx_d_q;
  state_t      state_q, state_d;
  logic [3:0]  pre_cnt_q, pre_cnt_d;
  logic        nib_ph_q, nib_ph_d;
  logic [3:0]  lo_nib_q, lo_nib_d;
  logic [10:0] byte_cnt_q, byte_cnt_d;
  logic        len_err_q, len_err_d;
  logic        data_fifo_wr_q, data_fifo_wr_d;
  logic [7:0]  data_fifo_dout_q, data_fifo_dout_d;
  logic        ptr_fifo_wr_q, ptr_fifo_wr_d;
  logic [15:0] ptr_fifo_dout_q, ptr_fifo_dout_d;
  logic        crc_init, crc_en;
  logic [7:0]  rx_byte;
  logic [31:0] crc_val;
  logic [15:0] desc;

  mii_rx_crc32 u_crc (
    .clk  (clk),
    .rstn (rstn),
    .init (crc_init),
    .en   (crc_en),
    .din  (rx_byte),
    .crc  (crc_val)
  );

  assign rx_byte = {rx_d_q, lo_nib_q};

  // A zero-byte frame never touched the CRC, so it reports only the length error.
  always_comb begin
    desc                 = '0;
    desc[CRC_ERR_BIT]    = (byte_cnt_q != 11'd0) && (crc_val != CRC_RESIDUE);
    desc[LEN_ERR_BIT]    = len_err_q || (byte_cnt_q < MIN_LEN_W);
    desc[ALIGN_ERR_BIT]  = nib_ph_q;
    desc[LEN_MSB:0]      = byte_cnt_q;
  end

  always_comb begin
    state_d          = state_q;
    pre_cnt_d        = pre_cnt_q;
    nib_ph_d         = nib_ph_q;
    lo_nib_d         = lo_nib_q;
    byte_cnt_d       = byte_cnt_q;
    len_err_d        = len_err_q;
    data_fifo_wr_d   = 1'b0;
    data_fifo_dout_d = data_fifo_dout_q;
    ptr_fifo_wr_d    = 1'b0;
    ptr_fifo_dout_d  = ptr_fifo_dout_q;
    crc_init         = 1'b0;
    crc_en           = 1'b0;
    case (state_q)
      IDLE: begin
        if (rx_dv_q && !rx_dv_d_q && (rx_d_q == 4'h5)) begin
          state_d   = PRE;
          pre_cnt_d = 4'd1;
        end
      end
      PRE: begin
        if (!rx_dv_q) begin
          state_d = IDLE;
        end else if (rx_d_q == 4'h5) begin
          if (pre_cnt_q != 4'hF) pre_cnt_d = pre_cnt_q + 4'd1;
        end else if ((rx_d_q == 4'hD) && (pre_cnt_q >= PRE_MIN_W)) begin
          if ((data_fifo_depth <= FIFO_AFULL_W) && !ptr_fifo_full) begin
            state_d    = DATA;
            crc_init   = 1'b1;
            nib_ph_d   = 1'b0;
            byte_cnt_d = 11'd0;
            len_err_d  = 1'b0;
          end else begin
            state_d = DROP;
          end
        end else begin
          state_d = DROP;
        end
      end
      DATA: begin
        if (!rx_dv_q) begin
          state_d         = DESC;
          ptr_fifo_wr_d   = 1'b1;
          ptr_fifo_dout_d = desc;
        end else if (!nib_ph_q) begin
          lo_nib_d = rx_d_q;
          nib_ph_d = 1'b1;
        end else begin
          nib_ph_d = 1'b0;
          crc_en   = 1'b1;
          if (byte_cnt_q < MAX_LEN_W) begin
            data_fifo_wr_d   = 1'b1;
            data_fifo_dout_d = rx_byte;
            byte_cnt_d       = byte_cnt_q + 11'd1;
          end else begin
            len_err_d = 1'b1;
          end
        end
      end
      DESC:    state_d = IDLE;
      DROP:    if (!rx_dv_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // rx_dv history resets high so a frame already in flight at reset release shows no rising edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_dv_q          <= 1'b1;
      rx_dv_d_q        <= 1'b1;
      rx_d_q           <= 4'h0;
      state_q          <= IDLE;
      pre_cnt_q        <= 4'd0;
      nib_ph_q         <= 1'b0;
      lo_nib_q         <= 4'h0;
      byte_cnt_q       <= 11'd0;
      len_err_q        <= 1'b0;
      data_fifo_wr_q   <= 1'b0;
      data_fifo_dout_q <= 8'h00;
      ptr_fifo_wr_q    <= 1'b0;
      ptr_fifo_dout_q  <= 16'h0000;
    end else begin
      rx_dv_q          <= rx_dv;
      rx_dv_d_q        <= rx_dv_q;
      rx_d_q           <= rx_d;
      state_q          <= state_d;
      pre_cnt_q        <= pre_cnt_d;
      nib_ph_q         <= nib_ph_d;
      lo_nib_q         <= lo_nib_d;
      byte_cnt_q       <= byte_cnt_d;
      len_err_q        <= len_err_d;
      data_fifo_wr_q   <= data_fifo_wr_d;
      data_fifo_dout_q <= data_fifo_dout_d;
      ptr_fifo_wr_q    <= ptr_fifo_wr_d;
      ptr_fifo_dout_q  <= ptr_fifo_dout_d;
    end
  end

  assign data_fifo_wr   = data_fifo_wr_q;
  assign data_fifo_dout = data_fifo_dout_q;
  assign ptr_fifo_wr    = ptr_fifo_wr_q;
  assign ptr_fifo_dout  = ptr_fifo_dout_q;

`ifdef MII_RX_STATS_EN
  logic [15:0] frames_ok_q, frames_ok_d;
  logic [15:0] frames_err_q, frames_err_d;
  logic [15:0] frames_drop_q, frames_drop_d;

  always_comb begin
    frames_ok_d   = frames_ok_q;
    frames_err_d  = frames_err_q;
    frames_drop_d = frames_drop_q;
    if (ptr_fifo_wr_d) begin
      if (ptr_fifo_dout_d[CRC_ERR_BIT:ALIGN_ERR_BIT] == 3'b000) frames_ok_d = frames_ok_q + 16'd1;
      else frames_err_d = frames_err_q + 16'd1;
    end
    if ((state_q == PRE) && (state_d == DROP)) frames_drop_d = frames_drop_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      frames_ok_q   <= 16'd0;
      frames_err_q  <= 16'd0;
      frames_drop_q <= 16'd0;
    end else begin
      frames_ok_q   <= frames_ok_d;
      frames_err_q  <= frames_err_d;
      frames_drop_q <= frames_drop_d;
    end
  end

  assign frames_ok   = frames_ok_q;
  assign frames_err  = frames_err_q;
  assign frames_drop = frames_drop_q;
`endif

endmodule

// File: tb/tb_mii_rx_frame.sv
// tb/tb_mii_rx_frame.sv - scoreboard bench for mii_rx_frame; expected bytes and descriptors are
// queued at stimulus time and popped by a monitor on each FIFO write strobe.
module tb_mii_rx_frame;

  logic        clk = 1'b0;
  logic        rstn;
  logic        rx_dv;
  logic [3:0]  rx_d;
  logic        data_fifo_wr;
  logic [7:0]  data_fifo_dout;
  logic [11:0] data_fifo_depth;
  logic        ptr_fifo_wr;
  logic [15:0] ptr_fifo_dout;
  logic        ptr_fifo_full;
`ifdef MII_RX_STATS_EN
  logic [15:0] frames_ok, frames_err, frames_drop;
  logic [15:0] snap;
`endif

  always #5 clk = ~clk;

  mii_rx_frame dut (
    .clk             (clk),
    .rstn            (rstn),
    .rx_dv           (rx_dv),
    .rx_d            (rx_d),
    .data_fifo_wr    (data_fifo_wr),
    .data_fifo_dout  (data_fifo_dout),
    .data_fifo_depth (data_fifo_depth),
    .ptr_fifo_wr     (ptr_fifo_wr),
    .ptr_fifo_dout   (ptr_fifo_dout),
    .ptr_fifo_full   (ptr_fifo_full)
`ifdef MII_RX_STATS_EN
    ,
    .frames_ok       (frames_ok),
    .frames_err      (frames_err),
    .frames_drop     (frames_drop)
`endif
  );

  int checks = 0;
  int failures = 0;
  int wr_count = 0;
  int desc_count = 0;
  logic [7:0]  exp_byte_q[$];
  logic [15:0] exp_desc_q[$];
  logic [7:0]  frame_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rstn && data_fifo_wr) begin
      wr_count++;
      if (exp_byte_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL data_unexpected actual=0x%0h expected=none", data_fifo_dout);
      end else begin
        check("data_byte", {24'h0, data_fifo_dout}, {24'h0, exp_byte_q.pop_front()});
      end
    end
    if (rstn && ptr_fifo_wr) begin
      desc_count++;
      if (exp_desc_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL desc_unexpected actual=0x%0h expected=none", ptr_fifo_dout);
      end else begin
        check("descriptor", {16'h0, ptr_fifo_dout}, {16'h0, exp_desc_q.pop_front()});
      end
    end
  end

  task automatic drive(input logic dv, input logic [3:0] d);
    @(posedge clk);
    #1;
    rx_dv = dv;
    rx_d  = d;
  endtask

  task automatic build_payload(input int n, input int seed);
    frame_q.delete();
    for (int i = 0; i < n; i++) frame_q.push_back(8'((i * 7 + seed) & 255));
  endtask

  task automatic append_fcs();
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < frame_q.size(); i++) begin
      for (int b = 0; b < 8; b++) begin
        if (c[0] ^ frame_q[i][b]) c = (c >> 1) ^ 32'hEDB88320;
        else c = c >> 1;
      end
    end
    c = ~c;
    for (int k = 0; k < 4; k++) frame_q.push_back(c[8*k +: 8]);
  endtask

  task automatic send_frame(input bit exp_data, input bit exp_desc, input logic [15:0] desc,
                            input bit extra_nib);
    int w0, d0, n_exp;
    logic [7:0] b;
    w0 = wr_count;
    d0 = desc_count;
    n_exp = 0;
    if (exp_data) begin
      for (int i = 0; i < frame_q.size() && i < 1518; i++) begin
        exp_byte_q.push_back(frame_q[i]);
        n_exp++;
      end
    end
    if (exp_desc) exp_desc_q.push_back(desc);
    for (int i = 0; i < 7; i++) drive(1'b1, 4'h5);
    drive(1'b1, 4'hD);
    for (int i = 0; i < frame_q.size(); i++) begin
      b = frame_q[i];
      drive(1'b1, b[3:0]);
      drive(1'b1, b[7:4]);
    end
    if (extra_nib) drive(1'b1, 4'h3);
    for (int i = 0; i < 6; i++) drive(1'b0, 4'h0);
    check("frame_writes", 32'(wr_count - w0), 32'(n_exp));
    check("frame_descs", 32'(desc_count - d0), exp_desc ? 32'd1 : 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, d0;
    logic [7:0] b;
    rstn = 1'b0;
    rx_dv = 1'b0;
    rx_d = 4'h0;
    data_fifo_depth = 12'd100;
    ptr_fifo_full = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data_wr", {31'h0, data_fifo_wr}, 32'h0);
    check("rst_data_dout", {24'h0, data_fifo_dout}, 32'h0);
    check("rst_ptr_wr", {31'h0, ptr_fifo_wr}, 32'h0);
    check("rst_ptr_dout", {16'h0, ptr_fifo_dout}, 32'h0);
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) drive(1'b0, 4'h0);

    build_payload(60, 3);
    append_fcs();
    send_frame(1'b1, 1'b1, 16'h0040, 1'b0);

    build_payload(60, 3);
    append_fcs();
    frame_q[5] = frame_q[5] ^ 8'h04;
    send_frame(1'b1, 1'b1, 16'h8040, 1'b0);

`ifdef MII_RX_STATS_EN
    snap = frames_err;
`endif
    build_payload(36, 11);
    append_fcs();
    send_frame(1'b1, 1'b1, 16'h4028, 1'b0);
`ifdef MII_RX_STATS_EN
    check("frames_err_inc", {16'h0, frames_err}, {16'h0, snap + 16'd1});
`endif

    build_payload(60, 5);
    append_fcs();
    send_frame(1'b1, 1'b1, 16'h2040, 1'b1);

`ifdef MII_RX_STATS_EN
    snap = frames_drop;
`endif
    data_fifo_depth = 12'd2567;
    build_payload(60, 9);
    append_fcs();
    send_frame(1'b0, 1'b0, 16'h0000, 1'b0);
`ifdef MII_RX_STATS_EN
    check("frames_drop_inc", {16'h0, frames_drop}, {16'h0, snap + 16'd1});
`endif
    data_fifo_depth = 12'd100;
    send_frame(1'b1, 1'b1, 16'h0040, 1'b0);

    frame_q.delete();
    send_frame(1'b1, 1'b1, 16'h4000, 1'b0);

    build_payload(1596, 1);
    append_fcs();
    send_frame(1'b1, 1'b1, 16'h45EE, 1'b0);

    // Reset in the middle of a frame: ten bytes land, then nothing more and no descriptor.
    build_payload(20, 13);
    w0 = wr_count;
    d0 = desc_count;
    for (int i = 0; i < 10; i++) exp_byte_q.push_back(frame_q[i]);
    for (int i = 0; i < 7; i++) drive(1'b1, 4'h5);
    drive(1'b1, 4'hD);
    for (int i = 0; i < 11; i++) begin
      b = frame_q[i];
      drive(1'b1, b[3:0]);
      drive(1'b1, b[7:4]);
    end
    @(negedge clk);
    #1;
    rstn = 1'b0;
    #1;
    check("midrst_data_wr", {31'h0, data_fifo_wr}, 32'h0);
    check("midrst_data_dout", {24'h0, data_fifo_dout}, 32'h0);
    check("midrst_ptr_wr", {31'h0, ptr_fifo_wr}, 32'h0);
    check("midrst_ptr_dout", {16'h0, ptr_fifo_dout}, 32'h0);
    for (int i = 0; i < 4; i++) drive(1'b1, 4'h5);
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) drive(1'b1, 4'h5);
    drive(1'b1, 4'hD);
    for (int i = 0; i < 16; i++) drive(1'b1, 4'hA);
    for (int i = 0; i < 6; i++) drive(1'b0, 4'h0);
    check("midrst_writes", 32'(wr_count - w0), 32'd10);
    check("midrst_descs", 32'(desc_count - d0), 32'd0);

    build_payload(60, 7);
    append_fcs();
    send_frame(1'b1, 1'b1, 16'h0040, 1'b0);

    for (int i = 0; i < 200 && (exp_byte_q.size() != 0 || exp_desc_q.size() != 0); i++)
      @(posedge clk);
    check("byte_queue_drained", 32'(exp_byte_q.size()), 32'd0);
    check("desc_queue_drained", 32'(exp_desc_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mii_rx_frame.md
Name: mii_rx_frame

Overview:
- MII receive-side frame engine, the counterpart of the MII transmit path, in the `clk` domain.
- Accepts 4-bit MII nibbles (`rx_dv`/`rx_d`), detects preamble/SFD and assembles bytes (low nibble first).
- Checks FCS, length and alignment.
- Writes payload bytes into an external 8-bit data FIFO, then one 16-bit descriptor per frame into an external pointer FIFO.
- The downstream switch core consumes descriptors and discards flagged frames.

Parameters:
- `MIN_LEN`, 64: minimum legal frame bytes, FCS included.
- `MAX_LEN`, 1518: maximum bytes written per frame; excess bytes are discarded.
- `FIFO_AFULL`, 2566: data FIFO depth above which a new frame is refused.
- `PRE_MIN`, 2: minimum 0x5 nibbles before SFD nibble 0xD.

Ports:
- `clk`  in  1  single clock; `rx_d`/`rx_dv` already synchronous to it.
- `rstn`  in  1  asynchronous active-low reset.
- `rx_dv`  in  1  MII receive data valid.
- `rx_d`  in  4  MII receive nibble.
- `data_fifo_wr`  out  1  data FIFO write strobe.
- `data_fifo_dout`  out  8  data FIFO write byte.
- `data_fifo_depth`  in  12  data FIFO write-side fill count.
- `ptr_fifo_wr`  out  1  descriptor FIFO write strobe.
- `ptr_fifo_dout`  out  16  descriptor.
- `ptr_fifo_full`  in  1  descriptor FIFO full.

Behaviour:
- Reset:
  - Clock and reset: one clock `clk`; reset `rstn` is asynchronous, active-low.
  - All outputs are 0 during reset; state is IDLE; counters are 0.
  - A frame in progress at reset is lost and no descriptor is written.
- Sampling: `rx_dv` and `rx_d` are registered once; `rx_dv_d` holds the previous sampled `rx_dv`.
- IDLE:
  - Go to PRE only if `rx_dv`=1, `rx_dv_d`=0 and `rx_d`=0x5; `pre_cnt`=1.
  - The rising-edge requirement means a frame already in flight when reset is released is ignored.
- PRE:
  - `rx_d`=0x5: increment `pre_cnt`, saturating at 15.
  - `rx_d`=0xD and `pre_cnt` >= `PRE_MIN`: admission check.
    - Admit if `data_fifo_depth` <= `FIFO_AFULL` and `!ptr_fifo_full`, then go to DATA.
    - Otherwise go to DROP.
  - Any other nibble: DROP.
  - `rx_dv`=0: IDLE.
- DATA:
  - `nib_ph` toggles per nibble. Phase 0 latches the low nibble.
  - Phase 1 forms byte {hi,lo} and feeds it to the CRC.
    - If `byte_cnt` < `MAX_LEN`: `data_fifo_wr`=1 for exactly one cycle on the next clk, with `data_fifo_dout`=byte, and `byte_cnt`++.
    - Otherwise: set `len_err`; no write and no count.
  - `rx_dv`=0: go to DESC.
    - If `nib_ph`=1 at that point (dangling nibble), set `align_err`; the dangling nibble is discarded.
- DESC:
  - One cycle; `ptr_fifo_wr`=1 for exactly one cycle.
  - `ptr_fifo_dout` fields:
    - [15] `crc_err`
    - [14] `len_err`, also set when `byte_cnt` < `MIN_LEN`
    - [13] `align_err`
    - [12:11] 0
    - [10:0] `byte_cnt`
  - Next state is IDLE.
  - A frame with zero bytes still writes a descriptor, 0x4000.
- DROP: no FIFO writes; wait for `rx_dv`=0, then IDLE.
- CRC:
  - Reflected CRC-32, polynomial 0xEDB88320, LSB-first.
  - Register is set to 0xFFFFFFFF on SFD acceptance and covers every received byte, including truncated ones.
  - `crc_err` = (register != 0xDEBB20E3) after the last byte.
- Latency:
  - Byte write occurs 1 clk after the high nibble is sampled.
  - Descriptor write occurs 1 clk after the cycle `rx_dv`=0 is sampled; it always follows that frame's last data write.
- Backpressure is checked only at SFD; a started frame is never aborted. The `FIFO_AFULL` margin covers `MAX_LEN`.
- The SFD of a new frame cannot be seen during DESC, because IDLE requires a `rx_dv` rising edge.

Optional Feature:
- Macro `MII_RX_STATS_EN`.
- When defined, adds three outputs: `frames_ok`[15:0], `frames_err`[15:0] and `frames_drop`[15:0].
  - They increment on a descriptor with bits [15:13]=0, on a descriptor with any error bit, and on entry to DROP, respectively.
  - Counters wrap at 0xFFFF to 0 and reset to 0.
- When undefined, neither these ports nor the counter logic exist.

Decomposition:
- Shared package holds:
  - state encoding IDLE/PRE/DATA/DESC/DROP;
  - descriptor bit positions (`CRC_ERR_BIT`=15, `LEN_ERR_BIT`=14, `ALIGN_ERR_BIT`=13, `LEN_MSB`=10);
  - `CRC_RESIDUE`=32'hDEBB20E3 and `CRC_INIT`=32'hFFFFFFFF.
- One sub-module: `mii_rx_crc32`, a byte-wide reflected CRC-32 with init/enable inputs and a 32-bit register output.

Test Plan:
- 7×0x5 then 0xD, then a 64-byte frame with valid FCS -> 64 `data_fifo_wr` pulses with correct bytes; descriptor 0x0040.
- Same frame with one payload bit flipped -> 64 writes; descriptor 0x8040.
- 40-byte frame with valid FCS -> descriptor 0x4028; `frames_err`+1 when `MII_RX_STATS_EN` is defined.
- 64-byte valid frame plus one extra nibble before `rx_dv` falls -> 64 writes; descriptor 0x2040.
- `data_fifo_depth`=2567 at SFD -> zero writes, no descriptor; a following frame with depth=100 is accepted normally.
- 1600-byte frame with valid FCS -> exactly 1518 writes; descriptor 0x45EE; reset asserted mid-frame -> outputs 0 and no descriptor.
